vga_timing_gen: RTL and testbench

- Raster-side initiator for the pixel-fetch interface. Generates the h_cnt/v_cnt scan coordinates consumed by the image address generators.
- Samples the 12-bit pixel word returned by the image memory and drives the VGA pins: hsync, vsync and 4:4:4 RGB.
- Runs on the 100 MHz board clock. Uses an internal pixel-rate enable instead of a derived clock.
- Aligns sync and blanking with the memory read latency so the picture lands on the correct pixel.

---
 rtl/vga_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync alignment and registered RGB pins.
// Define VGA_TEST_PATTERN_EN to replace pixel_in with eight colour bars.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIX_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_in,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        valid,
    output logic        pix_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;

    logic w_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_valid;
    logic w_hs_raw;
    logic w_vs_raw;

    assign w_tick   = (r_div == DIV_LAST);
    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_valid  = (r_h < H_VIS) && (r_v < V_VIS);
    assign w_hs_raw = !((r_h >= HS_START) && (r_h < HS_END));
    assign w_vs_raw = !((r_v >= VS_START) && (r_v < VS_END));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_last) begin
                r_h <= '0;
                r_v <= w_v_last ? '0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    // Delay line matching the image memory latency, one stage per pixel tick.
    logic [PIX_LAT-1:0] r_pv;
    logic [PIX_LAT-1:0] r_phs;
    logic [PIX_LAT-1:0] r_pvs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pv  <= '0;
            r_phs <= '1;
            r_pvs <= '1;
        end else if (w_tick) begin
            r_pv[0]  <= w_valid;
            r_phs[0] <= w_hs_raw;
            r_pvs[0] <= w_vs_raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_phs[i] <= r_phs[i-1];
                r_pvs[i] <= r_pvs[i-1];
            end
        end
    end

    logic [11:0] w_rgb_next;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [PIX_LAT-1:0][9:0] r_ph;
    logic [2:0]              w_bar;
    logic [11:0]             w_bar_rgb;
    logic                    w_unused_pix;

    assign w_unused_pix = ^pixel_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph <= '0;
        end else if (w_tick) begin
            r_ph[0] <= r_h;
            for (int i = 1; i < PIX_LAT; i++) begin
                r_ph[i] <= r_ph[i-1];
            end
        end
    end

    assign w_bar = 3'(r_ph[PIX_LAT-1] / 10'(BAR_W));

    // Bar order white..black falls out of the inverted index bits.
    assign w_bar_rgb = {{4{~w_bar[1]}}, {4{~w_bar[2]}}, {4{~w_bar[0]}}};

    always_comb begin
        w_rgb_next = 12'h000;
        if (r_pv[PIX_LAT-1]) begin
            w_rgb_next = w_bar_rgb;
        end
    end
`else
    always_comb begin
        w_rgb_next = 12'h000;
        if (r_pv[PIX_LAT-1]) begin
            w_rgb_next = pixel_in;
        end
    end
`endif

    logic        r_hsync;
    logic        r_vsync;
    logic [11:0] r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= 12'h000;
        end else if (w_tick) begin
            r_hsync <= r_phs[PIX_LAT-1];
            r_vsync <= r_pvs[PIX_LAT-1];
            r_rgb   <= w_rgb_next;
        end
    end

    assign h_cnt       = r_h;
    assign v_cnt       = r_v;
    assign valid       = w_valid;
    assign pix_tick    = w_tick;
    assign frame_start = w_tick & w_h_last & w_v_last;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vga_r       = r_rgb[11:8];
    assign vga_g       = r_rgb[7:4];
    assign vga_b       = r_rgb[3:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen on a reduced raster.
// Expected values come from tick-count arithmetic, not from the DUT.
module tb_vga_timing_gen;

    localparam int D     = 3;
    localparam int HA    = 16;
    localparam int HFP   = 2;
    localparam int HS    = 4;
    localparam int HBP   = 3;
    localparam int VA    = 8;
    localparam int VFP   = 1;
    localparam int VS    = 2;
    localparam int VBP   = 2;
    localparam int L     = 2;
    localparam int HT    = HA + HFP + HS + HBP;
    localparam int VT    = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT * D;

    typedef struct {
        int          h;
        int          v;
        bit          valid;
        bit          pt;
        bit          fs;
        bit          hs;
        bit          vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t q[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_in = 12'h000;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        valid;
    logic        pix_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;

    int checks   = 0;
    int failures = 0;

    int          e     = 0;
    bit          m_hs  = 1'b1;
    bit          m_vs  = 1'b1;
    logic [11:0] m_rgb = 12'h000;
    logic [11:0] seed  = 12'h000;

    int hs_low   = 0;
    int vs_low   = 0;
    bit hs_clean = 1'b0;
    bit vs_clean = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV (D),
        .H_ACTIVE(HA),
        .H_FP    (HFP),
        .H_SYNC  (HS),
        .H_BP    (HBP),
        .V_ACTIVE(VA),
        .V_FP    (VFP),
        .V_SYNC  (VS),
        .V_BP    (VBP),
        .PIX_LAT (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_in   (pixel_in),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .valid      (valid),
        .pix_tick   (pix_tick),
        .frame_start(frame_start),
        .hsync      (hsync),
        .vsync      (vsync),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b)
    );

    function automatic int hof(input int t);
        return (t % (HT * VT)) % HT;
    endfunction

    function automatic int vof(input int t);
        return (t % (HT * VT)) / HT;
    endfunction

    function automatic bit vis(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    function automatic bit hs_of(input int h);
        return !((h >= HA + HFP) && (h < HA + HFP + HS));
    endfunction

    function automatic bit vs_of(input int v);
        return !((v >= VA + VFP) && (v < VA + VFP + VS));
    endfunction

    function automatic logic [11:0] mem(input int h, input int v);
        return 12'(h * 37 + v * 101 + int'(seed));
    endfunction

    // mode 0: memory returning data for the coordinate L ticks back
    // mode 1: constant A5C, mode 2: fresh random word every clock
    function automatic logic [11:0] pix_for(input int mode);
        int c;
        c = e / D - L;
        if (mode == 1) return 12'hA5C;
        if (mode == 2 || c < 0) return 12'($urandom);
        return mem(hof(c), vof(c));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic [11:0] pix, input bit r);
        exp_t x;
        int   t;
        int   c;
        @(negedge clk);
        rst      = r;
        pixel_in = pix;
        if (r) begin
            e     = 0;
            m_hs  = 1'b1;
            m_vs  = 1'b1;
            m_rgb = 12'h000;
        end else begin
            if (e % D == D - 1) begin
                t = e / D + 1;
                c = t - L - 1;
                if (c < 0) begin
                    m_hs  = 1'b1;
                    m_vs  = 1'b1;
                    m_rgb = 12'h000;
                end else begin
                    m_hs  = hs_of(hof(c));
                    m_vs  = vs_of(vof(c));
                    m_rgb = vis(hof(c), vof(c)) ? pix : 12'h000;
                end
            end
            e++;
        end
        t       = e / D;
        x.h     = hof(t);
        x.v     = vof(t);
        x.valid = vis(x.h, x.v);
        x.pt    = (e % D == D - 1);
        x.fs    = x.pt && (x.h == HT - 1) && (x.v == VT - 1);
        x.hs    = m_hs;
        x.vs    = m_vs;
        x.rgb   = m_rgb;
        q.push_back(x);
    endtask

    task automatic async_rst_check();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_h_cnt", int'(h_cnt), 0);
        chk("async_v_cnt", int'(v_cnt), 0);
        chk("async_pix_tick", int'(pix_tick), 0);
        chk("async_hsync", int'(hsync), 1);
        chk("async_vsync", int'(vsync), 1);
        chk("async_rgb", int'({vga_r, vga_g, vga_b}), 0);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("h_cnt", int'(h_cnt), x.h);
                chk("v_cnt", int'(v_cnt), x.v);
                chk("valid", int'(valid), int'(x.valid));
                chk("pix_tick", int'(pix_tick), int'(x.pt));
                chk("frame_start", int'(frame_start), int'(x.fs));
                chk("hsync", int'(hsync), int'(x.hs));
                chk("vsync", int'(vsync), int'(x.vs));
                chk("rgb", int'({vga_r, vga_g, vga_b}), int'(x.rgb));
            end
            if (rst) begin
                hs_low   = 0;
                vs_low   = 0;
                hs_clean = 1'b0;
                vs_clean = 1'b0;
            end else begin
                if (!hsync) begin
                    hs_low++;
                end else begin
                    if (hs_low > 0 && hs_clean)
                        chk("hsync_width_clk", hs_low, HS * D);
                    hs_low   = 0;
                    hs_clean = 1'b1;
                end
                if (!vsync) begin
                    vs_low++;
                end else begin
                    if (vs_low > 0 && vs_clean)
                        chk("vsync_width_clk", vs_low, VS * HT * D);
                    vs_low   = 0;
                    vs_clean = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        int n;
        seed = 12'($urandom);
        repeat (3) step(12'($urandom), 1'b1);
        for (int i = 0; i < 2 * FRAME + 50; i++) step(pix_for(0), 1'b0);
        for (int i = 0; i < FRAME; i++) step(pix_for(1), 1'b0);
        for (int i = 0; i < FRAME; i++) step(pix_for(2), 1'b0);
        n = $urandom_range(60, FRAME - 60);
        for (int i = 0; i < n; i++) step(pix_for(2), 1'b0);
        async_rst_check();
        repeat (2) step(12'($urandom), 1'b1);
        for (int i = 0; i < FRAME + 40; i++) step(pix_for(0), 1'b0);
        repeat (4) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
